// File: rtl/touch_event_detector.sv
// Touch event detector: samples filtered x/y/z on a divided tick, debounces contact on z,
// and emits press/release/tap pulses, the held contact coordinate and per-sample motion deltas.
module touch_event_detector #(
    parameter logic [15:0] SAMPLE_DIV = 16'd50000,
    parameter logic [8:0]  Z_THRESH   = 9'd40,
    parameter int          DEBOUNCE   = 4,
    parameter logic [15:0] TAP_MAX    = 16'd200,
    parameter logic [8:0]  MOVE_TOL   = 9'd8
) (
    input  logic       cclk,
    input  logic       rstb,
    input  logic [8:0] x,
    input  logic [8:0] y,
    input  logic [8:0] z,
    output logic       touched,
    output logic [8:0] touch_x,
    output logic [8:0] touch_y,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       tap_pulse,
    output logic       motion_valid,
    output logic [9:0] dx,
    output logic [9:0] dy
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        PRESSED    = 2'd2,
        RELEASE_DB = 2'd3
    } state_t;

    localparam logic [15:0] DIV_LAST = SAMPLE_DIV - 16'd1;
    localparam logic [3:0]  DB_LIM   = DEBOUNCE[3:0];

    state_t      state_r;
    logic [15:0] div_cnt_r;
    logic [3:0]  db_cnt_r;
    logic [8:0]  origin_x_r;
    logic [8:0]  origin_y_r;
    logic [8:0]  prev_x_r;
    logic [8:0]  prev_y_r;
    logic [15:0] dur_r;
    logic        moved_r;

    logic        tick_s;
    logic        contact_s;
    logic [9:0]  dx_s;
    logic [9:0]  dy_s;
    logic [9:0]  ox_abs_s;
    logic [9:0]  oy_abs_s;
    logic        moved_s;
    logic        motion_s;
    logic [3:0]  db_inc_s;
    logic [15:0] dur_inc_s;
    logic [15:0] tap_dur_s;
    logic        tap_s;
    logic        press_fire_s;
    logic        release_fire_s;
    logic        track_s;

    // Per-tick decode: contact, deltas, origin distance and debounce firing conditions
    always_comb begin
        tick_s         = (div_cnt_r == DIV_LAST);
        contact_s      = (z >= Z_THRESH);
        dx_s           = {1'b0, x} - {1'b0, prev_x_r};
        dy_s           = {1'b0, y} - {1'b0, prev_y_r};
        ox_abs_s       = (x >= origin_x_r) ? ({1'b0, x} - {1'b0, origin_x_r})
                                           : ({1'b0, origin_x_r} - {1'b0, x});
        oy_abs_s       = (y >= origin_y_r) ? ({1'b0, y} - {1'b0, origin_y_r})
                                           : ({1'b0, origin_y_r} - {1'b0, y});
        moved_s        = moved_r || (ox_abs_s > {1'b0, MOVE_TOL}) || (oy_abs_s > {1'b0, MOVE_TOL});
        motion_s       = (dx_s != 10'd0) || (dy_s != 10'd0);
        db_inc_s       = db_cnt_r + 4'd1;
        dur_inc_s      = (dur_r == 16'hFFFF) ? dur_r : (dur_r + 16'd1);
        press_fire_s   = 1'b0;
        release_fire_s = 1'b0;
        tap_dur_s      = dur_r;
        track_s        = 1'b0;
        case (state_r)
            IDLE: begin
                press_fire_s = tick_s && contact_s && (DB_LIM == 4'd1);
            end
            PRESS_DB: begin
                press_fire_s = tick_s && contact_s && (db_inc_s == DB_LIM);
            end
            PRESSED: begin
                release_fire_s = tick_s && !contact_s && (DB_LIM == 4'd1);
                track_s        = tick_s && contact_s;
            end
            RELEASE_DB: begin
                // The release tick itself still counts toward the press duration
                release_fire_s = tick_s && !contact_s && (db_inc_s == DB_LIM);
                tap_dur_s      = dur_inc_s;
                track_s        = tick_s && contact_s;
            end
            default: begin
                press_fire_s   = 1'b0;
                release_fire_s = 1'b0;
            end
        endcase
        tap_s = (tap_dur_s <= TAP_MAX) && !moved_r;
    end

    // Tick divider, contact FSM and all registered outputs
    always_ff @(posedge cclk) begin
        if (!rstb) begin
            state_r       <= IDLE;
            div_cnt_r     <= 16'd0;
            db_cnt_r      <= 4'd0;
            origin_x_r    <= 9'd0;
            origin_y_r    <= 9'd0;
            prev_x_r      <= 9'd0;
            prev_y_r      <= 9'd0;
            dur_r         <= 16'd0;
            moved_r       <= 1'b0;
            touched       <= 1'b0;
            touch_x       <= 9'd0;
            touch_y       <= 9'd0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            tap_pulse     <= 1'b0;
            motion_valid  <= 1'b0;
            dx            <= 10'd0;
            dy            <= 10'd0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            tap_pulse     <= 1'b0;
            motion_valid  <= 1'b0;
            div_cnt_r     <= tick_s ? 16'd0 : (div_cnt_r + 16'd1);
            if (tick_s) begin
                case (state_r)
                    IDLE: begin
                        if (press_fire_s) begin
                            state_r  <= PRESSED;
                            db_cnt_r <= 4'd0;
                        end else if (contact_s) begin
                            state_r  <= PRESS_DB;
                            db_cnt_r <= 4'd1;
                        end else begin
                            db_cnt_r <= 4'd0;
                        end
                    end
                    PRESS_DB: begin
                        if (!contact_s) begin
                            state_r  <= IDLE;
                            db_cnt_r <= 4'd0;
                        end else if (press_fire_s) begin
                            state_r  <= PRESSED;
                            db_cnt_r <= 4'd0;
                        end else begin
                            db_cnt_r <= db_inc_s;
                        end
                    end
                    PRESSED: begin
                        if (release_fire_s) begin
                            state_r  <= IDLE;
                            db_cnt_r <= 4'd0;
                        end else if (!contact_s) begin
                            state_r  <= RELEASE_DB;
                            db_cnt_r <= 4'd1;
                        end else begin
                            db_cnt_r <= 4'd0;
                        end
                    end
                    RELEASE_DB: begin
                        if (contact_s) begin
                            state_r  <= PRESSED;
                            db_cnt_r <= 4'd0;
                        end else if (release_fire_s) begin
                            state_r  <= IDLE;
                            db_cnt_r <= 4'd0;
                            dur_r    <= dur_inc_s;
                        end else begin
                            db_cnt_r <= db_inc_s;
                            dur_r    <= dur_inc_s;
                        end
                    end
                    default: begin
                        state_r  <= IDLE;
                        db_cnt_r <= 4'd0;
                    end
                endcase

                if (press_fire_s) begin
                    touched     <= 1'b1;
                    press_pulse <= 1'b1;
                    touch_x     <= x;
                    touch_y     <= y;
                    origin_x_r  <= x;
                    origin_y_r  <= y;
                    prev_x_r    <= x;
                    prev_y_r    <= y;
                    dur_r       <= 16'd0;
                    moved_r     <= 1'b0;
                    dx          <= 10'd0;
                    dy          <= 10'd0;
                end

                if (release_fire_s) begin
                    touched       <= 1'b0;
                    release_pulse <= 1'b1;
                    tap_pulse     <= tap_s;
                end

                if (track_s) begin
                    touch_x      <= x;
                    touch_y      <= y;
                    prev_x_r     <= x;
                    prev_y_r     <= y;
                    dur_r        <= dur_inc_s;
                    moved_r      <= moved_s;
                    motion_valid <= motion_s;
                    if (motion_s) begin
                        dx <= dx_s;
                        dy <= dy_s;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_touch_event_detector.sv
// Self-checking bench for touch_event_detector: directed test-plan steps followed by random
// touch sessions, every cycle compared against a tick-level behavioural model.
module tb_touch_event_detector;

    localparam int DIV   = 4;
    localparam int DEB   = 3;
    localparam int TAPMX = 10;
    localparam int TOL   = 8;
    localparam int ZTH   = 40;

    logic       cclk = 1'b0;
    logic       rstb;
    logic [8:0] x, y, z;
    logic       touched, press_pulse, release_pulse, tap_pulse, motion_valid;
    logic [8:0] touch_x, touch_y;
    logic [9:0] dx, dy;

    touch_event_detector #(
        .SAMPLE_DIV (16'd4),
        .Z_THRESH   (9'd40),
        .DEBOUNCE   (3),
        .TAP_MAX    (16'd10),
        .MOVE_TOL   (9'd8)
    ) dut (
        .cclk          (cclk),
        .rstb          (rstb),
        .x             (x),
        .y             (y),
        .z             (z),
        .touched       (touched),
        .touch_x       (touch_x),
        .touch_y       (touch_y),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .tap_pulse     (tap_pulse),
        .motion_valid  (motion_valid),
        .dx            (dx),
        .dy            (dy)
    );

    always #5 cclk = ~cclk;

    int n_vec = 0;
    int n_err = 0;
    int phase = 0;

    // Reference model: contact state plus a run of disagreeing ticks
    bit   m_touched;
    int   m_run, m_dur, m_ox, m_oy, m_px, m_py;
    bit   m_moved;
    logic [8:0] e_tx, e_ty;
    logic [9:0] e_dx, e_dy;
    logic e_press, e_rel, e_tap, e_mv;
    logic t_press, t_rel, t_tap, t_mv;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        m_touched = 1'b0; m_run = 0; m_dur = 0; m_moved = 1'b0;
        m_ox = 0; m_oy = 0; m_px = 0; m_py = 0;
        e_tx = '0; e_ty = '0; e_dx = '0; e_dy = '0;
        e_press = 1'b0; e_rel = 1'b0; e_tap = 1'b0; e_mv = 1'b0;
    endtask

    task automatic model_tick(input int tx, input int ty, input int tz);
        bit c;
        int ndx, ndy;
        c = (tz >= ZTH);
        e_press = 1'b0; e_rel = 1'b0; e_tap = 1'b0; e_mv = 1'b0;
        if (!m_touched) begin
            if (c) begin
                m_run++;
                if (m_run == DEB) begin
                    m_touched = 1'b1; m_run = 0; e_press = 1'b1;
                    e_tx = 9'(tx); e_ty = 9'(ty);
                    m_ox = tx; m_oy = ty; m_px = tx; m_py = ty;
                    m_dur = 0; m_moved = 1'b0; e_dx = '0; e_dy = '0;
                end
            end else begin
                m_run = 0;
            end
        end else if (c) begin
            m_run = 0;
            ndx = tx - m_px;
            ndy = ty - m_py;
            e_mv = (ndx != 0) || (ndy != 0);
            if (e_mv) begin
                e_dx = 10'(ndx);
                e_dy = 10'(ndy);
            end
            e_tx = 9'(tx); e_ty = 9'(ty);
            m_px = tx; m_py = ty;
            if (m_dur < 65535) m_dur++;
            if (iabs(tx - m_ox) > TOL || iabs(ty - m_oy) > TOL) m_moved = 1'b1;
        end else begin
            if (m_run > 0 && m_dur < 65535) m_dur++;
            m_run++;
            if (m_run == DEB) begin
                m_touched = 1'b0; m_run = 0; e_rel = 1'b1;
                e_tap = (m_dur <= TAPMX) && !m_moved;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("touched", 16'(touched), 16'(m_touched));
        chk("touch_x", 16'(touch_x), 16'(e_tx));
        chk("touch_y", 16'(touch_y), 16'(e_ty));
        chk("press_pulse", 16'(press_pulse), 16'(e_press));
        chk("release_pulse", 16'(release_pulse), 16'(e_rel));
        chk("tap_pulse", 16'(tap_pulse), 16'(e_tap));
        chk("motion_valid", 16'(motion_valid), 16'(e_mv));
        chk("dx", 16'(dx), 16'(e_dx));
        chk("dy", 16'(dy), 16'(e_dy));
    endtask

    // One cclk cycle: real values on the tick edge, random glitches otherwise
    task automatic clk_cycle(input int tx, input int ty, input int tz);
        bit is_tick;
        is_tick = (phase == DIV - 1);
        if (is_tick) begin
            x = 9'(tx); y = 9'(ty); z = 9'(tz);
            model_tick(tx, ty, tz);
        end else begin
            x = 9'($urandom_range(0, 511));
            y = 9'($urandom_range(0, 511));
            z = 9'($urandom_range(0, 511));
            e_press = 1'b0; e_rel = 1'b0; e_tap = 1'b0; e_mv = 1'b0;
        end
        phase = is_tick ? 0 : phase + 1;
        @(negedge cclk);
        check_all();
        if (is_tick) begin
            t_press = press_pulse; t_rel = release_pulse; t_tap = tap_pulse; t_mv = motion_valid;
        end
    endtask

    task automatic do_tick(input int tx, input int ty, input int tz);
        repeat (DIV) clk_cycle(tx, ty, tz);
    endtask

    task automatic reset_cycle();
        rstb = 1'b0;
        x = 9'($urandom_range(0, 511));
        y = 9'($urandom_range(0, 511));
        z = 9'($urandom_range(0, 511));
        model_reset();
        @(negedge cclk);
        check_all();
        rstb = 1'b1;
        phase = 0;
    endtask

    initial begin
        int rx, ry, zlvl;
        rstb = 1'b0; x = '0; y = '0; z = '0;
        model_reset();
        repeat (3) @(negedge cclk);
        check_all();
        rstb = 1'b1;
        phase = 0;

        // 1: press after three contact ticks
        do_tick(100, 100, 50);
        do_tick(100, 100, 50);
        chk("t1_no_early_press", 16'(t_press), 16'd0);
        do_tick(100, 100, 50);
        chk("t1_press", 16'(t_press), 16'd1);
        chk("t1_touched", 16'(touched), 16'd1);
        chk("t1_touch_x", 16'(touch_x), 16'd100);
        chk("t1_touch_y", 16'(touch_y), 16'd100);

        // 2: short still press then release is a tap
        repeat (5) do_tick(100, 100, 50);
        repeat (3) do_tick(100, 100, 20);
        chk("t2_release", 16'(t_rel), 16'd1);
        chk("t2_tap", 16'(t_tap), 16'd1);
        chk("t2_touched", 16'(touched), 16'd0);
        chk("t2_hold_x", 16'(touch_x), 16'd100);

        // 3: motion deltas, movement kills the tap
        repeat (3) do_tick(100, 100, 50);
        do_tick(112, 95, 50);
        chk("t3_motion", 16'(t_mv), 16'd1);
        chk("t3_dx", 16'(dx), 16'h00C);
        chk("t3_dy", 16'(dy), 16'h3FB);
        repeat (3) do_tick(112, 95, 20);
        chk("t3_release", 16'(t_rel), 16'd1);
        chk("t3_no_tap", 16'(t_tap), 16'd0);

        // 4: bounce before press and a one-tick dip while pressed
        do_tick(200, 150, 50);
        do_tick(200, 150, 20);
        do_tick(200, 150, 50);
        do_tick(200, 150, 50);
        chk("t4_no_press_yet", 16'(t_press), 16'd0);
        do_tick(200, 150, 50);
        chk("t4_press", 16'(t_press), 16'd1);
        do_tick(200, 150, 20);
        do_tick(200, 150, 50);
        chk("t4_no_release", 16'(t_rel), 16'd0);
        chk("t4_still_touched", 16'(touched), 16'd1);
        repeat (3) do_tick(200, 150, 20);

        // 5: long press at the exact threshold, release at threshold-1
        repeat (3) do_tick(300, 200, 40);
        chk("t5_press_at_40", 16'(t_press), 16'd1);
        repeat (20) do_tick(300, 200, 40);
        repeat (3) do_tick(300, 200, 39);
        chk("t5_release_at_39", 16'(t_rel), 16'd1);
        chk("t5_long_no_tap", 16'(t_tap), 16'd0);

        // 6: reset while pressed, then the divider restarts from zero
        repeat (4) do_tick(50, 60, 90);
        clk_cycle(50, 60, 90);
        reset_cycle();
        chk("t6_touched_clr", 16'(touched), 16'd0);
        chk("t6_no_release", 16'(release_pulse), 16'd0);
        repeat (3) do_tick(10, 20, 90);
        chk("t6_repress", 16'(t_press), 16'd1);
        repeat (3) do_tick(10, 20, 0);

        // Random sessions: sticky z levels, small random walks in x/y
        rx = 240; ry = 136; zlvl = 0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: zlvl = $urandom_range(0, 39);
                    1: zlvl = $urandom_range(40, 511);
                    2: zlvl = 39;
                    default: zlvl = 40;
                endcase
            end
            if ($urandom_range(0, 1) == 1) begin
                rx += $urandom_range(0, 6) - 3;
                ry += $urandom_range(0, 6) - 3;
            end
            if ($urandom_range(0, 40) == 0) begin
                rx = $urandom_range(0, 479);
                ry = $urandom_range(0, 272);
            end
            rx = (rx < 0) ? 0 : ((rx > 479) ? 479 : rx);
            ry = (ry < 0) ? 0 : ((ry > 272) ? 272 : ry);
            do_tick(rx, ry, zlvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/touch_event_detector.md
Name: touch_event_detector

Overview:
- Downstream consumer of the touchpad controller's filtered x/y/z outputs (9-bit each).
- Samples those outputs at a fixed tick rate and debounces contact using a pressure threshold on z.
- Emits press/release/tap events, a held contact coordinate, and per-sample motion deltas for the debugger UI logic.

Parameters:
SAMPLE_DIV, 16'd50000, cclk cycles per sample tick (valid range 2..65535)
Z_THRESH, 9'd40, contact when z >= Z_THRESH
DEBOUNCE, 4, consecutive agreeing ticks needed to change contact state (valid range 1..15)
TAP_MAX, 16'd200, max press duration in ticks that still qualifies as a tap
MOVE_TOL, 9'd8, max |x - origin_x| or |y - origin_y| in pixels that still qualifies as a tap

Ports:
cclk  in  1  system clock
rstb  in  1  reset
x  in  9  filtered X, 0..479
y  in  9  filtered Y, 0..272
z  in  9  filtered pressure
touched  out  1  debounced contact state
touch_x  out  9  last sampled X while touched; held after release
touch_y  out  9  last sampled Y while touched; held after release
press_pulse  out  1  one-cycle pulse on debounced press
release_pulse  out  1  one-cycle pulse on debounced release
tap_pulse  out  1  one-cycle pulse, coincident with release_pulse, when the press qualifies as a tap
motion_valid  out  1  one-cycle pulse when dx or dy is nonzero
dx  out  10  signed (x_now - x_prev) during contact; two's complement
dy  out  10  signed (y_now - y_prev) during contact; two's complement

Behaviour:
- Reset: rstb is synchronous, active-low, sampled on cclk. All outputs reset to 0, state resets to IDLE, and every counter and origin/prev register resets to 0.
- Tick: a counter runs 0..SAMPLE_DIV-1 and wraps to 0. tick=1 for the single cycle in which counter==SAMPLE_DIV-1.
- All FSM, counter and output updates occur only on the edge where tick=1. The exception is the pulses, which clear on the next cclk edge.
- x, y and z are sampled directly on the tick edge. contact = (z >= Z_THRESH), unsigned compare.
- db_cnt (4-bit) counts consecutive ticks that agree with the pending state change, including the first such tick. The state transition fires when the new db_cnt would equal DEBOUNCE.
- FSM states and transitions, evaluated per tick:
  - IDLE: if contact, set db_cnt=1; if DEBOUNCE==1, perform the press entry immediately; else go to PRESS_DB.
  - PRESS_DB:
    - No contact: go to IDLE, db_cnt=0.
    - Contact: db_cnt++.
    - On reaching DEBOUNCE, press entry: go to PRESSED; touched=1; press_pulse=1; touch_x/y, origin_x/y and prev_x/y all <= x/y; dur=0; moved=0.
  - PRESSED:
    - Contact: touch_x/y <= x/y; dx=x-prev_x, dy=y-prev_y (10-bit signed); motion_valid=1 iff either delta is nonzero; prev <= x/y; dur <= dur+1, saturating at 16'hFFFF.
    - moved is set sticky if |x-origin_x| > MOVE_TOL or |y-origin_y| > MOVE_TOL.
    - No contact: db_cnt=1; if DEBOUNCE==1, perform the release exit immediately; else go to RELEASE_DB. Coordinates are not updated on this tick.
  - RELEASE_DB:
    - Contact: return to PRESSED, db_cnt=0, and apply the PRESSED contact actions on this tick. dur continues counting; there is no new press_pulse.
    - No contact: db_cnt++; dur keeps incrementing, saturating.
    - On reaching DEBOUNCE, release exit: go to IDLE; touched=0; release_pulse=1; tap_pulse = (dur <= TAP_MAX) && !moved. touch_x/y hold their last values.
- press_pulse, release_pulse, tap_pulse and motion_valid:
  - Each is high for exactly one cclk cycle, beginning at the edge where tick=1.
  - They are never asserted twice per tick.
  - press_pulse and release_pulse are never asserted on the same cycle.
- dx/dy hold their values between motion_valid pulses. They are cleared to 0 on press entry.
- Absolute-difference arithmetic is 10-bit, so no wrap at 0 or 479.
- Reset mid-press: the FSM returns to IDLE and no release_pulse is emitted.
- Inputs are asynchronous to the tick phase; any glitch between ticks has no effect.

Test Plan:
Use SAMPLE_DIV=4, DEBOUNCE=3, TAP_MAX=10, MOVE_TOL=8, Z_THRESH=40 for all scenarios.
1. Hold z=50, x=100, y=100 for 3 ticks -> press_pulse 1 cycle on the 3rd tick edge (cycle 11 after reset release); touched=1; touch_x=100, touch_y=100.
2. Press as in 1, then z=20 for 3 ticks after 5 ticks pressed -> release_pulse and tap_pulse together in the same cycle; touched=0; touch_x=100 held.
3. While pressed, step x 100->112 and y 100->95 on the next tick -> motion_valid=1, dx=+12 (10'h00C), dy=-5 (10'h3FB); moved set, so the later release gives release_pulse with tap_pulse=0.
4. z bounce during press: 50, 20, 50, 50, 50 -> no press_pulse until the 3rd consecutive contact tick; a single-tick z=20 dip while PRESSED gives no release_pulse and touched stays 1.
5. Hold contact for 20 ticks, then release -> release_pulse=1, tap_pulse=0 (dur>10); z exactly 40 counts as contact, 39 does not.
6. Assert rstb=0 for 1 cycle while PRESSED -> all outputs 0 on the next edge; no release_pulse; the tick counter restarts at 0.
